// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit feeding one register-file write port.
// Latency: 33 cycles from the accepting edge to the single write-back cycle.
// Backpressure: start is taken only in IDLE; while busy=1 it is ignored, with no queuing.
//
// Ports:
//   clk, rste       : clock, synchronous active-high reset
//   start, op       : request pulse and operation (00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR)
//   opa, opb, dst   : operands from read ports A/B and destination register number
//   busy, done      : operation in progress (write-back included), completion strobe
//   we, wp, din     : register-file write port (registered, held outside write-back)
module mdu_seq #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rste,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [31:0]   opa,
  input  logic [31:0]   opb,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [AW-1:0] wp,
  output logic [31:0]   din
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [31:0]   b_q;
  // Shared working register: product {hi,lo} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [63:0]   acc_q, acc_d;
  logic [4:0]    cnt_q;
  // Set once the 32nd iteration has been applied; the next RUN edge writes back.
  logic          last_q;

  logic [32:0]   mul_sum;
  logic [32:0]   div_sh;
  logic          div_ge;
  logic [31:0]   div_rem;
  logic [31:0]   result;

  // Iteration datapath
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh  = {acc_q[63:32], acc_q[31]};
    div_ge  = (div_sh >= {1'b0, b_q});
    // When div_ge holds the true difference is below 2^32, so a 32-bit wrap is exact.
    div_rem = div_sh[31:0] - b_q;
    acc_d   = acc_q;
    if (!op_q[1]) begin
      // Shift-add: carry out of the upper add becomes the new MSB.
      acc_d = {mul_sum, acc_q[31:1]};
    end else if (div_ge) begin
      acc_d = {div_rem, acc_q[30:0], 1'b1};
    end else begin
      acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
    end
    // Both MULHI and DIVR live in the upper half; divide-by-zero falls out naturally
    // (every subtract succeeds: quotient all ones, remainder equals the dividend).
    result = op_q[0] ? acc_q[63:32] : acc_q[31:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_q) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rste) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      dst_q   <= '0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      wp      <= '0;
      din     <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            dst_q  <= dst;
            b_q    <= opb;
            acc_q  <= {32'd0, opa};
            cnt_q  <= 5'd0;
            last_q <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (!last_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) last_q <= 1'b1;
          end else begin
            we   <= 1'b1;
            done <= 1'b1;
            wp   <= dst_q;
            din  <= result;
          end
        end
        WB: begin
          we   <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          we   <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: reset state, multiply/divide results, divide by zero,
// ignored start while busy, and reset abort mid-operation.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rste;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [3:0]  dst;
  logic        busy, done, we;
  logic [3:0]  wp;
  logic [31:0] din;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.AW(4)) dut (
    .clk   (clk),
    .rste  (rste),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .dst   (dst),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .wp    (wp),
    .din   (din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Issues one op, scrambles the inputs after
  // acceptance, optionally pokes a second start at RUN cycle 'poke', then checks the
  // write-back cycle and the idle cycle after it. Returns at the negedge after WB.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] d,
                        input logic [31:0] exp, input int poke);
    int n;
    bit busy_ok;
    op = o; opa = a; opb = b; dst = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; opa = ~a; opb = b + 32'd1; dst = ~d;
    n = 0;
    busy_ok = 1'b1;
    while (!we && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd3; dst = 4'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, " we"}, {63'd0, we}, 64'd1);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy_wb"}, {63'd0, busy}, 64'd1);
    chk({tag, " wp"}, {60'd0, wp}, {60'd0, d});
    chk({tag, " din"}, {32'd0, din}, {32'd0, exp});
    @(negedge clk);
    chk({tag, " we_off"}, {63'd0, we}, 64'd0);
    chk({tag, " done_off"}, {63'd0, done}, 64'd0);
    chk({tag, " busy_off"}, {63'd0, busy}, 64'd0);
    chk({tag, " din_hold"}, {32'd0, din}, {32'd0, exp});
  endtask

  initial begin
    int we_cnt;
    rste = 1'b1; start = 1'b0; op = 2'b00; opa = 32'd0; opb = 32'd0; dst = 4'd0;
    repeat (2) @(negedge clk);
    start = 1'b1;  // start under reset must be overridden
    @(negedge clk);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst we", {63'd0, we}, 64'd0);
    chk("rst wp", {60'd0, wp}, 64'd0);
    chk("rst din", {32'd0, din}, 64'd0);
    start = 1'b0;
    rste = 1'b0;
    @(negedge clk);

    run_op("mullo7x6", 2'b00, 32'd7, 32'd6, 4'd3, 32'h0000002A, -1);
    // back-to-back: next start in the first IDLE cycle after WB
    run_op("mulhi_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE, -1);
    run_op("mullo_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'h00000001, -1);
    run_op("mulhi_2p16", 2'b01, 32'h00010000, 32'h00010000, 4'd0, 32'h00000001, -1);
    run_op("divq100_7", 2'b10, 32'd100, 32'd7, 4'd6, 32'h0000000E, -1);
    run_op("divr100_7", 2'b11, 32'd100, 32'd7, 4'd7, 32'h00000002, -1);
    run_op("divq_by0", 2'b10, 32'h1234, 32'd0, 4'd8, 32'hFFFFFFFF, -1);
    run_op("divr_by0", 2'b11, 32'h1234, 32'd0, 4'd9, 32'h00001234, -1);
    run_op("divq_max", 2'b10, 32'hFFFFFFFF, 32'd1, 4'd15, 32'hFFFFFFFF, -1);
    run_op("divr_big", 2'b11, 32'hFFFFFFFF, 32'h80000000, 4'd1, 32'h7FFFFFFF, -1);

    // second start during RUN must be ignored: one write, first op's result
    run_op("poke", 2'b00, 32'd7, 32'd6, 4'd2, 32'h0000002A, 5);
    we_cnt = 0;
    repeat (40) begin
      if (we) we_cnt++;
      @(negedge clk);
    end
    chk("poke extra_we", 64'(we_cnt), 64'd0);

    // reset at RUN cycle 10 aborts the op
    op = 2'b00; opa = 32'd7; opb = 32'd6; dst = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rste = 1'b1;
    @(negedge clk);
    rste = 1'b0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort we", {63'd0, we}, 64'd0);
    we_cnt = 0;
    repeat (40) begin
      if (we || done) we_cnt++;
      @(negedge clk);
    end
    chk("abort no_we", 64'(we_cnt), 64'd0);
    run_op("after_rst", 2'b10, 32'd100, 32'd7, 4'd11, 32'h0000000E, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
